// File: rtl/lights_sequencer_if.sv
// Mode/button request side and registered RGB/tick result side of the lights sequencer.
interface lights_sequencer_if #(
    parameter int CHANNELS = 2,
    parameter int COLOUR_W = 8
);
    logic [1:0]                     mode;
    logic [CHANNELS-1:0]            button;
    logic [CHANNELS*3*COLOUR_W-1:0] light;
    logic                           step_tick;

    modport master (output mode, output button, input light, input step_tick);
    modport slave  (input mode, input button, output light, output step_tick);
endinterface

// File: rtl/lights_sequencer.sv
// Multi-channel colour sequencer: per-channel 3-bit index stepped by button or shared prescaler, mapped to RGB.
// Outputs registered, 1-cycle latency from mode/button; no backpressure, the LED stage always accepts.
module lights_sequencer #(
    parameter int CHANNELS = 2,
    parameter int COLOUR_W = 8,
    parameter int PRESCALE = 4,
    parameter int EDGE     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    lights_sequencer_if.slave bus
);
    localparam int WORD_W = 3 * COLOUR_W;
    localparam int LIGHT_W = CHANNELS * WORD_W;
    localparam int PW = ($clog2(PRESCALE) < 1) ? 1 : $clog2(PRESCALE);

    typedef enum logic [1:0] {
        MODE_WHITE  = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

    mode_t                     cur_mode;
    logic [CHANNELS-1:0][2:0]  idx;
    logic [CHANNELS-1:0][2:0]  idx_next;
    logic [CHANNELS-1:0]       button_d;
    logic [CHANNELS-1:0]       manual_req;
    logic [PW-1:0]             pre_cnt;
    logic                      wrap;
    logic                      step_tick;
    logic [LIGHT_W-1:0]        light;
    logic [LIGHT_W-1:0]        light_next;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        // 0 and 7 are only reachable from reset/corruption; both rejoin the cycle at 1
        return (i >= 3'd1 && i <= 3'd5) ? i + 3'd1 : 3'd1;
    endfunction

    function automatic logic [WORD_W-1:0] palette(input logic [2:0] i);
        return {{COLOUR_W{i[2]}}, {COLOUR_W{i[1]}}, {COLOUR_W{i[0]}}};
    endfunction

    assign cur_mode   = mode_t'(bus.mode);
    assign wrap       = (cur_mode == MODE_AUTO) && (pre_cnt == PW'(PRESCALE - 1));
    assign manual_req = (EDGE != 0) ? (bus.button & ~button_d) : bus.button;

    always_comb begin
        idx_next   = idx;
        light_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (cur_mode)
                MODE_MANUAL: if (manual_req[c]) idx_next[c] = next_idx(idx[c]);
                MODE_AUTO:   if (wrap)          idx_next[c] = next_idx(idx[c]);
                default:     ;
            endcase
            case (cur_mode)
                MODE_WHITE: light_next[c*WORD_W +: WORD_W] = '1;
                MODE_OFF:   light_next[c*WORD_W +: WORD_W] = '0;
                default:    light_next[c*WORD_W +: WORD_W] = palette(idx_next[c]);
            endcase
        end
    end

    // Button history runs in every mode so entering MANUAL with a held button is not seen as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            button_d  <= '0;
            pre_cnt   <= '0;
            step_tick <= 1'b0;
            light     <= '1;
        end else begin
            idx       <= idx_next;
            button_d  <= bus.button;
            if (cur_mode != MODE_AUTO || wrap) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            step_tick <= wrap;
            light     <= light_next;
        end
    end

    assign bus.light     = light;
    assign bus.step_tick = step_tick;
endmodule

// File: tb/tb_lights_sequencer.sv
// Directed bench for lights_sequencer: level (EDGE=0) and edge (EDGE=1) instances checked every cycle against a rule model.
module tb_lights_sequencer;
    localparam int CH = 2;
    localparam int CW = 8;
    localparam int PRESCALE = 4;
    localparam int LW = CH * 3 * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CH-1:0] button = '0;

    int checks = 0;
    int errors = 0;

    lights_sequencer_if #(.CHANNELS(CH), .COLOUR_W(CW)) ia ();
    lights_sequencer_if #(.CHANNELS(CH), .COLOUR_W(CW)) ib ();

    assign ia.mode   = mode;
    assign ia.button = button;
    assign ib.mode   = mode;
    assign ib.button = button;

    lights_sequencer #(.CHANNELS(CH), .COLOUR_W(CW), .PRESCALE(PRESCALE), .EDGE(0))
        dut_level (.clk(clk), .rst_n(rst_n), .bus(ia));
    lights_sequencer #(.CHANNELS(CH), .COLOUR_W(CW), .PRESCALE(PRESCALE), .EDGE(1))
        dut_edge (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    // Rule model: integer indices, integer prescale count, previous button snapshot
    int            m_idx [2][CH] = '{default: 0};
    int            m_cnt = 0;
    logic          m_tick = 1'b0;
    logic [CH-1:0] m_bd = '0;
    logic [LW-1:0] m_light [2] = '{default: '1};

    function automatic int nxt(int i);
        return (i >= 1 && i <= 5) ? i + 1 : 1;
    endfunction

    function automatic logic [3*CW-1:0] pal(int i);
        logic [2:0] b;
        b = 3'(i);
        return {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                for (int c = 0; c < CH; c++) m_idx[e][c] = 0;
                m_light[e] = '1;
            end
            m_cnt  = 0;
            m_tick = 1'b0;
            m_bd   = '0;
        end else begin
            logic tick_now;
            logic req;
            tick_now = (mode == 2'b10) && (m_cnt == PRESCALE - 1);
            for (int e = 0; e < 2; e++) begin
                for (int c = 0; c < CH; c++) begin
                    if (mode == 2'b01) req = (e == 1) ? (button[c] && !m_bd[c]) : button[c];
                    else if (mode == 2'b10) req = tick_now;
                    else req = 1'b0;
                    if (req) m_idx[e][c] = nxt(m_idx[e][c]);
                    if (mode == 2'b00) m_light[e][c*3*CW +: 3*CW] = '1;
                    else if (mode == 2'b11) m_light[e][c*3*CW +: 3*CW] = '0;
                    else m_light[e][c*3*CW +: 3*CW] = pal(m_idx[e][c]);
                end
            end
            m_cnt  = (mode == 2'b10) ? (m_cnt + 1) % PRESCALE : 0;
            m_tick = tick_now;
            m_bd   = button;
        end
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then compare both DUTs against the model
    task automatic step();
        @(negedge clk);
        chk("model_light_level", ia.light, m_light[0]);
        chk("model_light_edge", ib.light, m_light[1]);
        chk("model_tick_level", LW'(ia.step_tick), LW'(m_tick));
        chk("model_tick_edge", LW'(ib.step_tick), LW'(m_tick));
    endtask

    logic [23:0] seq_tbl [7];

    initial begin
        seq_tbl = '{24'h0000FF, 24'h00FF00, 24'h00FFFF, 24'hFF0000,
                    24'hFF00FF, 24'hFFFF00, 24'h0000FF};

        // Reset with arbitrary inputs
        rst_n = 1'b0; mode = 2'b10; button = 2'b11;
        step();
        step();
        chk("reset_light", ia.light, 48'hFFFFFF_FFFFFF);
        chk("reset_tick", LW'(ia.step_tick), '0);

        // MANUAL level stepping on ch0, including the 6->1 wrap
        rst_n = 1'b1; mode = 2'b01; button = 2'b01;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("manual_seq_%0d", k), ia.light, {24'h000000, seq_tbl[k]});
        end

        // Edge mode: held button steps once, release/press steps again
        button = 2'b10;
        repeat (5) step();
        chk("edge_hold_once", ib.light, {24'h0000FF, 24'h0000FF});
        button = 2'b00;
        step();
        button = 2'b10;
        step();
        chk("edge_second_press", ib.light, {24'h00FF00, 24'h0000FF});

        // AUTO from ch0=3, ch1=0 with buttons held (ignored)
        button = 2'b00; rst_n = 1'b0;
        step();
        rst_n = 1'b1; mode = 2'b01; button = 2'b01;
        repeat (3) step();
        chk("auto_setup", ia.light, {24'h000000, 24'h00FFFF});
        mode = 2'b10; button = 2'b11;
        repeat (3) step();
        chk("auto_no_tick_yet", LW'(ia.step_tick), '0);
        step();
        chk("auto_tick1", LW'(ia.step_tick), LW'(1));
        chk("auto_after_tick1", ia.light, {24'h0000FF, 24'hFF0000});
        repeat (4) step();
        chk("auto_tick2", LW'(ia.step_tick), LW'(1));
        chk("auto_after_tick2", ia.light, {24'h00FF00, 24'hFF00FF});

        // Asynchronous reset mid-AUTO: outputs go white before the next edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_light", ia.light, 48'hFFFFFF_FFFFFF);
        chk("async_rst_light_edge", ib.light, 48'hFFFFFF_FFFFFF);
        chk("async_rst_tick", LW'(ia.step_tick), '0);
        button = 2'b00;
        step();

        // Mode override: WHITE, OFF, then back to MANUAL with index kept
        rst_n = 1'b1; mode = 2'b01; button = 2'b01;
        repeat (4) step();
        button = 2'b00; mode = 2'b00;
        step();
        chk("override_white", ia.light, 48'hFFFFFF_FFFFFF);
        mode = 2'b11;
        step();
        chk("override_off", ia.light, 48'h000000_000000);
        mode = 2'b01;
        step();
        chk("override_restore", ia.light, {24'h000000, 24'hFF0000});

        // AUTO re-entry: leave one cycle before the tick, next tick is a full period later
        mode = 2'b10;
        repeat (3) step();
        chk("reentry_pre_tick", LW'(ia.step_tick), '0);
        mode = 2'b01;
        step();
        mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("reentry_quiet_%0d", k), LW'(ia.step_tick), '0);
        end
        step();
        chk("reentry_tick", LW'(ia.step_tick), LW'(1));
        chk("reentry_light", ia.light, {24'h0000FF, 24'hFF00FF});

        mode = 2'b00;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
